serial_subtractor: RTL

Bit-serial W-bit subtractor computing A − B, LSB first, through one full-subtractor cell and a borrow flip-flop. This is the subtraction counterpart to the team's combinational full-adder cell, built for area-constrained datapaths. Operands load in parallel on a start/done handshake. The result is presented in parallel with borrow-out and signed-overflow flags.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 107 ++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Master drives operands and start; slave returns status and result.
interface serial_subtractor_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial A-B, LSB first, through one full-subtractor cell.
// Parallel load on start, parallel result with borrow and overflow.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q;
  logic [W-1:0]  sa_q;
  logic [W-1:0]  sb_q;
  logic [W-1:0]  sr_q;
  logic [W-1:0]  diff_q;
  logic [CW-1:0] cnt_q;
  logic          brw_q;
  logic          amsb_q;
  logic          bmsb_q;
  logic          bout_q;
  logic          ovf_q;
  logic          busy_q;
  logic          done_q;

  logic          d_bit;
  logic          brw_d;
  logic [W-1:0]  sr_d;
  logic          ovf_d;
  logic          last_bit;

  // Full-subtractor cell on the current LSBs
  assign d_bit    = sa_q[0] ^ sb_q[0] ^ brw_q;
  assign brw_d    = (~sa_q[0] & sb_q[0])
                  | (~(sa_q[0] ^ sb_q[0]) & brw_q);
  assign sr_d     = {d_bit, sr_q[W-1:1]};
  assign ovf_d    = (amsb_q != bmsb_q)
                  && (sr_d[W-1] != amsb_q);
  assign last_bit = (cnt_q == CW'(W-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            amsb_q  <= bus.a[W-1];
            bmsb_q  <= bus.b[W-1];
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_d;
          brw_q <= brw_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_bit) begin
            state_q <= DONE;
            diff_q  <= sr_d;
            bout_q  <= brw_d;
            ovf_q   <= ovf_d;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule
